// File: rtl/btn_step_pkg.sv
// Shared command encoding, button indices and priority decode for btn_step_counter.
package btn_step_pkg;

  typedef enum logic [2:0] {
    CMD_HOLD,
    CMD_CLEAR,
    CMD_INC,
    CMD_DEC,
    CMD_DEC1
  } cmd_t;

  localparam int BTN_DEC1 = 0;
  localparam int BTN_CLR  = 1;
  localparam int BTN_INC  = 2;
  localparam int BTN_DEC  = 3;

  // CLEAR wins over everything; INC+DEC together cancel out to HOLD.
  function automatic cmd_t decode_cmd(input logic [3:0] p);
    cmd_t c;
    if (p[BTN_CLR])                  c = CMD_CLEAR;
    else if (p[BTN_INC] && p[BTN_DEC]) c = CMD_HOLD;
    else if (p[BTN_INC])             c = CMD_INC;
    else if (p[BTN_DEC])             c = CMD_DEC;
    else if (p[BTN_DEC1])            c = CMD_DEC1;
    else                             c = CMD_HOLD;
    return c;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus hold-time debounce for one raw push-button.
// Output pressed is normalised so that 1 means the button is held down.
module btn_debounce #(
  parameter int DEB_CYCLES = 65536,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pressed
);

  localparam int            CW       = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic          INV      = (ACTIVE_LOW != 0);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;
  logic          lvl;

  assign lvl = sync[1] ^ INV;

  // Sync flops reset to the released raw level so no false press follows reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= {2{INV}};
      cnt     <= '0;
      pressed <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      if (lvl == pressed) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        pressed <= lvl;
        cnt     <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_step_counter.sv
// Button-driven up/down LED counter with debounce, enable-tick divider and wrap/saturate.
// Define BTN_STEP_EDGE_MODE_EN for one step per press; default repeats while held.
module btn_step_counter
  import btn_step_pkg::*;
#(
  parameter int              WIDTH          = 8,
  parameter int              DIV            = 10000000,
  parameter longint unsigned STEP           = 2,
  parameter int              DEB_CYCLES     = 65536,
  parameter int              SAT_MODE       = 0,
  parameter int              BTN_ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       button,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             at_max,
  output logic             at_min
);

  localparam int               DW       = $clog2(DIV);
  localparam logic [DW-1:0]    DIV_LAST = DW'(DIV - 1);
  localparam logic [WIDTH:0]   STEP_X   = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0]   ONE_X    = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic             SAT      = (SAT_MODE != 0);

  logic [3:0]       pressed;
  logic [DW-1:0]    div;
  cmd_t             cmd;
  logic [WIDTH:0]   sum, diff, dec1;
  logic [WIDTH-1:0] nxt;

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_deb (
      .clk    (clk),
      .rst_n  (rst_n),
      .raw    (button[i]),
      .pressed(pressed[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                div <= '0;
    else if (div == DIV_LAST)  div <= '0;
    else                       div <= div + 1'b1;
  end

  assign tick = (div == DIV_LAST);

`ifdef BTN_STEP_EDGE_MODE_EN
  logic [3:0] pressed_q, pending, rise;

  assign rise = pressed & ~pressed_q;

  // A rise landing on the tick cycle is carried into the next tick's window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pressed_q <= '0;
      pending   <= '0;
    end else begin
      pressed_q <= pressed;
      if (tick) pending <= rise;
      else      pending <= pending | rise;
    end
  end

  assign cmd = decode_cmd(pending);
`else
  assign cmd = decode_cmd(pressed);
`endif

  // The extra top bit of each result flags overflow/underflow.
  always_comb begin
    sum  = {1'b0, count} + STEP_X;
    diff = {1'b0, count} - STEP_X;
    dec1 = {1'b0, count} - ONE_X;
    nxt  = count;
    case (cmd)
      CMD_CLEAR: nxt = '0;
      CMD_INC:   nxt = (SAT && sum[WIDTH])  ? CNT_MAX : sum[WIDTH-1:0];
      CMD_DEC:   nxt = (SAT && diff[WIDTH]) ? '0      : diff[WIDTH-1:0];
      CMD_DEC1:  nxt = (SAT && dec1[WIDTH]) ? '0      : dec1[WIDTH-1:0];
      default:   nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    count <= '0;
    else if (tick) count <= nxt;
  end

  assign led    = ~count;
  assign at_max = (count == CNT_MAX);
  assign at_min = (count == '0);

endmodule
